bus_arbiter: RTL
================

Name: bus_arbiter

Overview:
- Round-robin arbiter that shares one `bus`-style data channel between N requesters.
- Each requester presents a valid/data pair. The arbiter grants one requester at a time and forwards its beats to the shared downstream port (e.g. a `buffer` input) with valid/ready handshake.
- A grant is held for up to BL beats (burst) to amortise arbitration. Fairness comes from a rotating priority pointer.

Parameters:
- N, 4, number of requesters (2..16)
- DW, 8, data width per beat
- BL, 4, maximum beats per grant (>=1)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous reset, active-low
- req_vld  input  N  per-requester beat valid
- req_dat  input  N*DW  requester data; requester k occupies bits [k*DW +: DW]
- req_rdy  output  N  per-requester beat accepted
- out_vld  output  1  shared channel valid
- out_dat  output  DW  shared channel data
- out_rdy  input  1  shared channel ready from downstream
- gnt_vld  output  1  a requester currently holds the grant
- gnt_idx  output  $clog2(N) (min 1)  index of granted requester

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, ptr=0, gnt_idx=0, beat cnt=0, gnt_vld=0. Outputs out_vld=0, out_dat=0 and req_rdy=0 are driven combinationally from state. Reset mid-burst drops the burst with no completion.
- Arbitration function: first k with req_vld[k]=1, searching k = ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (mod N).
- State IDLE:
  - gnt_vld=0, out_vld=0, req_rdy=0.
  - If any req_vld: gnt_idx <= arb result, cnt <= 0, next state GRANT.
  - Arbitration latency is 1 cycle: the first beat can transfer in the cycle after the request is seen.
- State GRANT:
  - gnt_vld=1.
  - out_vld = req_vld[gnt_idx], out_dat = req_dat slice gnt_idx (zero when out_vld=0).
  - req_rdy[gnt_idx] = out_rdy; all other req_rdy=0. This path is purely combinational.
  - Transfer = out_vld & out_rdy. On a transfer without release: cnt <= cnt+1.
  - Release condition: (transfer & cnt==BL-1) | (req_vld[gnt_idx]==0).
  - On release: ptr <= (gnt_idx+1) mod N, cnt <= 0.
    - If any req_vld is set in the same cycle, re-arbitrate using the new ptr and stay in GRANT with the new gnt_idx (zero bubble).
    - Otherwise go to IDLE.
  - A requester that is released but still valid in the release cycle may be regranted only if it is first by rotation from the new ptr, e.g. it is the sole requester.
- Handshake rules:
  - A requester must not drop req_vld or change req_dat while its req_rdy=0 and req_vld=1 mid-beat. Dropping valid between beats is legal and ends the burst.
  - The arbiter never changes gnt_idx while out_vld=1 and out_rdy=0.
- Widths:
  - ptr and gnt_idx are $clog2(N) bits; the wrap from N-1 to 0 is explicit and must also work for non-power-of-2 N.
  - cnt is $clog2(BL) bits, min 1.
  - BL=1 gives single-beat grants with strict rotation.
- No combinational path from out_rdy to out_vld.

Test Plan:
- Reset, then req_vld=4'b0001 with 6 beats queued, out_rdy=1, BL=4 -> gnt_vld rises 1 cycle later with gnt_idx=0. Beats 0-3 pass, then release. Sole requester is regranted with no idle cycle, and the remaining 2 beats pass.
- req_vld=4'b1111 constant, out_rdy=1, BL=4 -> grants in order 0,1,2,3,0 with exactly 4 beats each. out_dat matches the requester slice every cycle and there are no bubbles.
- Granted requester 2, out_rdy held 0 for 5 cycles -> gnt_idx=2, out_vld=1, out_dat stable, req_rdy=0 throughout. Beat transfers in the cycle out_rdy=1.
- Requester 1 drops req_vld after 2 of 4 beats while requester 3 is valid -> release in that cycle, gnt_idx=3 next cycle, ptr=2.
- N=3, ptr wrap: grants 2 then 0 with req_vld=3'b101 -> correct mod-3 rotation, and index 3 is never produced.
- rst asserted low mid-burst (cnt=2) -> gnt_vld, out_vld and req_rdy go 0 immediately. After release, req_vld=4'b0100 is granted with ptr=0 semantics (idx 2).

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter sharing one valid/ready data channel
// between N requesters. A grant is held for up to BL beats. On release the
// priority pointer moves to the requester after the one just served.
//
// Ports:
//   clk      - system clock, all state on rising edge
//   rst      - asynchronous reset, active-low
//   req_vld  - [N] per-requester beat valid
//   req_dat  - [N*DW] requester data, requester k at [k*DW +: DW]
//   req_rdy  - [N] per-requester beat accepted (out_rdy steered to grantee)
//   out_vld  - shared channel valid
//   out_dat  - [DW] shared channel data (zero when out_vld=0)
//   out_rdy  - shared channel ready from downstream
//   gnt_vld  - a requester currently holds the grant
//   gnt_idx  - index of granted requester
module bus_arbiter #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int BL = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1,
    localparam int CW = (BL > 1) ? $clog2(BL) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_vld,
    input  logic [N*DW-1:0] req_dat,
    output logic [N-1:0]    req_rdy,
    output logic            out_vld,
    output logic [DW-1:0]   out_dat,
    input  logic            out_rdy,
    output logic            gnt_vld,
    output logic [IW-1:0]   gnt_idx
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] ptr, ptr_nxt, gnt_nxt, ptr_inc;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          xfer, rel;
    logic [DW-1:0] dat_arr [N];

    // First valid requester searching ptr, ptr+1, ... with wrap at N.
    // The sum is one bit wider so the mod-N wrap is exact for any N.
    function automatic logic [IW-1:0] arb(input logic [N-1:0] v,
                                          input logic [IW-1:0] p);
        logic [IW-1:0] r;
        logic [IW:0]   sum;
        logic          found;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, p} + (IW+1)'(i);
            if (sum >= (IW+1)'(N))
                sum = sum - (IW+1)'(N);
            if (!found && v[sum[IW-1:0]]) begin
                found = 1'b1;
                r     = sum[IW-1:0];
            end
        end
        return r;
    endfunction

    always_comb begin
        for (int k = 0; k < N; k++)
            dat_arr[k] = req_dat[k*DW +: DW];
    end

    assign ptr_inc = (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + 1'b1;

    // out_vld depends only on state and req_vld, never on out_rdy.
    always_comb begin
        gnt_vld = 1'b0;
        out_vld = 1'b0;
        out_dat = '0;
        req_rdy = '0;
        if (state == GRANT) begin
            gnt_vld          = 1'b1;
            out_vld          = req_vld[gnt_idx];
            out_dat          = out_vld ? dat_arr[gnt_idx] : '0;
            req_rdy[gnt_idx] = out_rdy;
        end
    end

    assign xfer = out_vld & out_rdy;
    // A stalled beat (out_vld & !out_rdy) can never release, so gnt_idx
    // is stable while data is waiting downstream.
    assign rel  = (xfer && cnt == CW'(BL-1)) || !req_vld[gnt_idx];

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt_idx;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (|req_vld) begin
                    gnt_nxt   = arb(req_vld, ptr);
                    cnt_nxt   = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (rel) begin
                    ptr_nxt = ptr_inc;
                    cnt_nxt = '0;
                    // Re-arbitrate in the release cycle: no idle bubble.
                    if (|req_vld)
                        gnt_nxt = arb(req_vld, ptr_inc);
                    else
                        state_nxt = IDLE;
                end else if (xfer) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt_idx <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            gnt_idx <= gnt_nxt;
            cnt     <= cnt_nxt;
        end
    end

endmodule
